// File: rtl/bufr_clk_divider.sv
// bufr_clk_divider: regional clock buffer with optional integer divide (BYPASS, 1..8).
// Divided outputs align to rising edges of clk_i; rst_i clears asynchronously.
`timescale 1ns/1ps
`default_nettype none

module bufr_clk_divider #(
  parameter string BUFR_DIVIDE = "BYPASS",
  parameter string SIM_DEVICE  = "7SERIES"
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce_i,
  output logic clk_o
);

  // 0 = bypass, 1..8 = divide ratio, -1 = illegal
  localparam int C_DIV =
    (BUFR_DIVIDE == "BYPASS") ? 0 :
    (BUFR_DIVIDE == "1")      ? 1 :
    (BUFR_DIVIDE == "2")      ? 2 :
    (BUFR_DIVIDE == "3")      ? 3 :
    (BUFR_DIVIDE == "4")      ? 4 :
    (BUFR_DIVIDE == "5")      ? 5 :
    (BUFR_DIVIDE == "6")      ? 6 :
    (BUFR_DIVIDE == "7")      ? 7 :
    (BUFR_DIVIDE == "8")      ? 8 : -1;

  generate
    if (C_DIV < 0 || SIM_DEVICE != "7SERIES") begin : g_bad_param
      $fatal(1, "bufr_clk_divider: illegal BUFR_DIVIDE or SIM_DEVICE parameter");
      assign clk_o = 1'b0;
      logic w_unused;
      assign w_unused = clk_i ^ rst_i ^ ce_i;
    end else if (C_DIV == 0) begin : g_bypass
      assign clk_o = clk_i;
      logic w_unused;
      assign w_unused = rst_i ^ ce_i;
    end else if (C_DIV == 1) begin : g_div1
      logic en_q;

      // Enable changes only while clk_i is low, so the gated clock never runts.
      always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) en_q <= 1'b0;
        else       en_q <= ce_i;
      end

      assign clk_o = clk_i & en_q;
    end else begin : g_divn
      localparam logic [2:0] C_LAST = 3'(C_DIV - 1);
      localparam logic [2:0] C_HIGH = 3'((C_DIV + 1) / 2);

      logic [2:0] cnt_q, cnt_d;
      logic       out_q, out_d;

      always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (ce_i) begin
          if (cnt_q == 3'd0)        out_d = 1'b1;
          else if (cnt_q == C_HIGH) out_d = 1'b0;
          cnt_d = (cnt_q == C_LAST) ? 3'd0 : cnt_q + 3'd1;
        end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cnt_q <= 3'd0;
          out_q <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          out_q <= out_d;
        end
      end

      assign clk_o = out_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bufr_clk_divider.sv
// tb_bufr_clk_divider: drives BYPASS, "1" and "2".."8" instances from one clock
// with random CE and CLR pulses, checking against a phase-count reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_bufr_clk_divider;

  logic       clk;
  logic       rst;
  logic       ce;
  logic       o_byp;
  logic       o_d1;
  logic [8:2] o_n;

  int checks;
  int errors;

  // Reference state: active edges seen since the last clear, and the div-1 enable.
  int   k_edges;
  logic en_m;

  initial clk = 1'b0;
  always #1.25 clk = ~clk;

  bufr_clk_divider #(.BUFR_DIVIDE("BYPASS"), .SIM_DEVICE("7SERIES")) u_byp (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .clk_o(o_byp)
  );

  bufr_clk_divider #(.BUFR_DIVIDE("1"), .SIM_DEVICE("7SERIES")) u_d1 (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .clk_o(o_d1)
  );

  genvar g;
  generate
    for (g = 2; g <= 8; g++) begin : g_divn
      localparam string C_S = (g == 2) ? "2" : (g == 3) ? "3" : (g == 4) ? "4" :
                              (g == 5) ? "5" : (g == 6) ? "6" : (g == 7) ? "7" : "8";
      bufr_clk_divider #(.BUFR_DIVIDE(C_S), .SIM_DEVICE("7SERIES")) u_dut (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .clk_o(o_n[g])
      );
    end
  endgenerate

  task automatic chk_eq(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
    end
  endtask

  // High for the first ceil(n/2) of every n active edges, counting from edge 1.
  function automatic logic exp_div(input int n, input int k);
    if (k < 1) return 1'b0;
    return ((k - 1) % n) < ((n + 1) / 2);
  endfunction

  task automatic check_high_phase(input string when);
    chk_eq({when, " byp"}, o_byp, 1'b1);
    chk_eq({when, " d1"}, o_d1, en_m);
    for (int n = 2; n <= 8; n++)
      chk_eq($sformatf("%s d%0d k=%0d", when, n, k_edges), o_n[n], exp_div(n, k_edges));
  endtask

  task automatic cycle(input logic c, input logic pulse_clr);
    @(negedge clk);
    en_m = ce;
    #0.2;
    ce = c;
    #0.2;
    chk_eq("low byp", o_byp, 1'b0);
    chk_eq("low d1", o_d1, 1'b0);
    @(posedge clk);
    if (ce) k_edges++;
    #0.2;
    check_high_phase("edge");
    if (pulse_clr) begin
      #0.2;
      rst = 1'b1;
      #0.1;
      k_edges = 0;
      en_m    = 1'b0;
      check_high_phase("clr");
      #0.2;
      rst = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    k_edges = 0;
    en_m    = 1'b0;
    rst     = 1'b1;
    ce      = 1'b0;

    repeat (3) begin
      @(posedge clk);
      #0.2;
      check_high_phase("reset");
    end
    @(negedge clk);
    #0.3;
    rst = 1'b0;

    // Free run after release: first active edge must start the high phase.
    repeat (20) cycle(1'b1, 1'b0);
    // CE pause mid-period, then resume.
    repeat (4) cycle(1'b0, 1'b0);
    repeat (10) cycle(1'b1, 1'b0);
    // Clear during a high phase, then watch the restarted phase.
    cycle(1'b1, 1'b1);
    repeat (12) cycle(1'b1, 1'b0);

    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
